fpu_issue_arbiter: RTL
======================

// Module: fpu_issue_arbiter
// PURPOSE
// Shares one fpnew_top instance between NumReq requesters. A round-robin arbiter
// picks one request per cycle into a one-entry issue register that drives the
// FPU input handshake. The requester index rides in the FPU tag; results are
// routed back to the issuing requester. A credit counter limits operations in flight.
// PARAMETERS
// NumReq    2   number of requesters (>=2)
// Width     16  operand/result width; equals fpnew_top WIDTH
// MaxOutst  4   max ops accepted but not yet returned (issue reg + FPU), >=1
// IdxW      $clog2(NumReq)  derived; tag width
// PORTS
// clk_i           in   1               clock
// rst_ni          in   1               asynchronous reset, active low
// flush_i         in   1               sync flush: kill issue reg and in-flight ops
// req_valid_i     in   NumReq          request valid per requester
// req_ready_o     out  NumReq          request accepted (one-hot or zero)
// req_operands_i  in   NumReq*3*Width  three operands per requester
// req_op_i        in   NumReq*4        fpnew_pkg::operation_e per requester
// req_op_mod_i    in   NumReq          op modifier per requester
// req_rnd_i       in   NumReq*3        fpnew_pkg::roundmode_e per requester
// rsp_valid_o     out  NumReq          result valid, one-hot by returned tag
// rsp_ready_i     in   NumReq          requester can take result
// rsp_result_o    out  Width           shared result bus
// rsp_status_o    out  5               shared fpnew_pkg::status_t
// fpu_in_valid_o  out  1               to fpnew_top in_valid_i
// fpu_in_ready_i  in   1               from fpnew_top in_ready_o
// fpu_operands_o  out  3*Width         registered operands
// fpu_op_o / fpu_op_mod_o / fpu_rnd_o  out  4/1/3  registered op fields
// fpu_tag_o       out  IdxW            registered requester index
// fpu_out_valid_i in   1               from fpnew_top out_valid_o
// fpu_out_ready_o out  1               to fpnew_top out_ready_i
// fpu_result_i / fpu_status_i / fpu_tag_i  in  Width/5/IdxW  FPU outputs
// fpu_flush_o     out  1               to fpnew_top flush_i (= flush_i)
// busy_o          out  1               credit count != 0
// BEHAVIOUR
// - Reset: issue reg empty, fpu_in_valid_o=0, data/tag regs 0, rr pointer=0, count=0.
//   req_ready_o, rsp_valid_o and busy_o are 0 while in reset.
// - FSM over the issue reg: EMPTY -> FULL when a request is accepted.
//   FULL -> EMPTY on fpu_in_valid_o&fpu_in_ready_i with no new accept.
//   FULL stays FULL on handshake plus a new accept (back-to-back, 1 op/cycle).
//   Any state -> EMPTY on flush_i.
// - can_accept = !flush_i & (EMPTY | fpu_in_ready_i) & (count<MaxOutst | ret_hs).
//   ret_hs = fpu_out_valid_i & fpu_out_ready_o.
// - Grant: the first asserted req_valid_i at or after the rr pointer (wrapping).
//   req_ready_o[g]=can_accept. On accept, capture fields and tag=g; rr pointer <= g+1 mod NumReq.
// - While FULL and !fpu_in_ready_i, registered fields are held stable (AXI rule).
// - Issue latency: accept in cycle N -> fpu_in_valid_o in cycle N+1.
// - Return path is combinational:
//   rsp_valid_o[fpu_tag_i] = fpu_out_valid_i & !flush_i; fpu_out_ready_o = rsp_ready_i[fpu_tag_i].
//   rsp_result_o and rsp_status_o pass fpu_result_i and fpu_status_i through.
// - Count: +1 on accept, -1 on ret_hs, unchanged when both happen; never exceeds MaxOutst.
// - Flush: fpu_flush_o=flush_i, count<=0, issue reg cleared, no accept or response that cycle.
// - Reset mid-operation: all state returns to reset values immediately; in-flight results are lost.
// TESTING
// 1. Reset, then req_valid_i=2'b11 held, fpu_in_ready_i=1 -> grants alternate 0,1,0,1; fpu_tag_o follows one cycle later.
// 2. MaxOutst=4, fpu_out_valid_i=0, one requester valid -> 4 accepts, then req_ready_o=0 and busy_o=1.
// 3. At count=4, return tag 1 with rsp_ready_i[1]=1 and a new request in the same cycle -> accepted; count stays 4.
// 4. FULL with fpu_in_ready_i=0 for 3 cycles, req_valid_i changing -> fpu_operands_o and fpu_tag_o stable; req_ready_o=0.
// 5. Result tag=1 with rsp_ready_i=2'b01 -> rsp_valid_o=2'b10, fpu_out_ready_o=0; raise rsp_ready_i[1] -> handshake, count-1.
// 6. flush_i pulse with count=3 and reg FULL -> fpu_flush_o=1; next cycle count=0, fpu_in_valid_o=0, busy_o=0.

Source files
------------

// File: rtl/fpu_issue_arbiter.sv
// fpu_issue_arbiter
// Shares one fpnew_top instance between NumReq requesters. A round-robin
// arbiter grants one request per cycle into a single-entry issue register.
// That register drives the FPU input handshake. The requester index travels
// in the FPU tag, so each result is steered back to the requester that
// issued it. A credit counter caps the number of operations that have been
// accepted but not yet returned (issue register plus FPU pipeline).
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   flush_i                  synchronous flush of issue register and credits
//   req_valid_i/req_ready_o  per-requester request handshake (ready one-hot)
//   req_operands_i, req_op_i, req_op_mod_i, req_rnd_i
//                            per-requester operation fields, packed by index
//   rsp_valid_o/rsp_ready_i  per-requester result handshake (valid one-hot)
//   rsp_result_o, rsp_status_o  shared result bus
//   fpu_in_valid_o/fpu_in_ready_i   handshake towards fpnew_top input
//   fpu_operands_o, fpu_op_o, fpu_op_mod_o, fpu_rnd_o, fpu_tag_o
//                            registered operation fields
//   fpu_out_valid_i/fpu_out_ready_o handshake from fpnew_top output
//   fpu_result_i, fpu_status_i, fpu_tag_i  FPU result fields
//   fpu_flush_o              flush forwarded to fpnew_top
//   busy_o                   at least one operation outstanding
module fpu_issue_arbiter #(
  parameter int unsigned NumReq   = 2,
  parameter int unsigned Width    = 16,
  parameter int unsigned MaxOutst = 4,
  parameter int unsigned IdxW     = $clog2(NumReq)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic [NumReq-1:0]          req_valid_i,
  output logic [NumReq-1:0]          req_ready_o,
  input  logic [NumReq*3*Width-1:0]  req_operands_i,
  input  logic [NumReq*4-1:0]        req_op_i,
  input  logic [NumReq-1:0]          req_op_mod_i,
  input  logic [NumReq*3-1:0]        req_rnd_i,
  output logic [NumReq-1:0]          rsp_valid_o,
  input  logic [NumReq-1:0]          rsp_ready_i,
  output logic [Width-1:0]           rsp_result_o,
  output logic [4:0]                 rsp_status_o,
  output logic                       fpu_in_valid_o,
  input  logic                       fpu_in_ready_i,
  output logic [3*Width-1:0]         fpu_operands_o,
  output logic [3:0]                 fpu_op_o,
  output logic                       fpu_op_mod_o,
  output logic [2:0]                 fpu_rnd_o,
  output logic [IdxW-1:0]            fpu_tag_o,
  input  logic                       fpu_out_valid_i,
  output logic                       fpu_out_ready_o,
  input  logic [Width-1:0]           fpu_result_i,
  input  logic [4:0]                 fpu_status_i,
  input  logic [IdxW-1:0]            fpu_tag_i,
  output logic                       fpu_flush_o,
  output logic                       busy_o
);

  localparam int unsigned CntW = $clog2(MaxOutst + 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } issue_state_e;

  issue_state_e state_q, state_d;

  logic [IdxW-1:0]    rr_q;
  logic [CntW-1:0]    count_q;
  logic [3*Width-1:0] operands_q;
  logic [3:0]         op_q;
  logic               op_mod_q;
  logic [2:0]         rnd_q;
  logic [IdxW-1:0]    tag_q;

  logic               grant_found;
  logic [IdxW-1:0]    grant_idx;
  logic [IdxW-1:0]    cand_idx;
  logic [IdxW-1:0]    rr_next;
  logic               ret_hs;
  logic               can_accept;
  logic               accept;

  // Round-robin search: the first valid requester at or after the pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand_idx = IdxW'((32'(rr_q) + k) % NumReq);
      if (!grant_found && req_valid_i[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign rr_next = (grant_idx == IdxW'(NumReq - 1)) ? '0 : grant_idx + 1'b1;

  // A returning result frees a credit in the same cycle, so a full credit
  // pool can still accept when a response handshake happens alongside.
  assign ret_hs     = fpu_out_valid_i & fpu_out_ready_o;
  assign can_accept = !flush_i
                    & ((state_q == EMPTY) | fpu_in_ready_i)
                    & ((count_q < CntW'(MaxOutst)) | ret_hs);
  assign accept     = can_accept & grant_found;

  // Outputs that are combinational are forced low while reset is asserted.
  always_comb begin
    req_ready_o = '0;
    if (rst_ni && grant_found) begin
      req_ready_o[grant_idx] = can_accept;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    if (rst_ni && fpu_out_valid_i && !flush_i) begin
      rsp_valid_o[fpu_tag_i] = 1'b1;
    end
  end

  assign fpu_out_ready_o = rsp_ready_i[fpu_tag_i];
  assign rsp_result_o    = fpu_result_i;
  assign rsp_status_o    = fpu_status_i;
  assign fpu_flush_o     = flush_i;
  assign busy_o          = (count_q != '0);

  // Issue-register occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // A new accept refills the register even as the old entry is handed off,
  // giving one operation per cycle.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else if (accept) begin
      state_d = FULL;
    end else if ((state_q == FULL) && fpu_in_ready_i) begin
      state_d = EMPTY;
    end
  end

  assign fpu_in_valid_o = (state_q == FULL);

  // Fields are only written on accept, which keeps them stable while the
  // FPU stalls the input handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      operands_q <= '0;
      op_q       <= '0;
      op_mod_q   <= 1'b0;
      rnd_q      <= '0;
      tag_q      <= '0;
      rr_q       <= '0;
    end else if (accept) begin
      operands_q <= req_operands_i[32'(grant_idx)*3*Width +: 3*Width];
      op_q       <= req_op_i[32'(grant_idx)*4 +: 4];
      op_mod_q   <= req_op_mod_i[grant_idx];
      rnd_q      <= req_rnd_i[32'(grant_idx)*3 +: 3];
      tag_q      <= grant_idx;
      rr_q       <= rr_next;
    end
  end

  assign fpu_operands_o = operands_q;
  assign fpu_op_o       = op_q;
  assign fpu_op_mod_o   = op_mod_q;
  assign fpu_rnd_o      = rnd_q;
  assign fpu_tag_o      = tag_q;

  // Credit counter: accepted minus returned operations.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (flush_i) begin
      count_q <= '0;
    end else if (accept && !ret_hs) begin
      count_q <= count_q + 1'b1;
    end else if (!accept && ret_hs && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

endmodule
